regfile_alu_core: RTL and testbench
===================================

// Module: regfile_alu_core
// PURPOSE
//  Parametrised register-file + ALU execution core; successor to the 16x8 three-operand ALU block.
//  Accepts one instruction (opcode, srcA, srcB, dest) per valid/ready handshake and runs it through READ/EXEC/WB.
//  MUL is multi-cycle shift-add; other ops are single-cycle EXEC. A side load port initialises registers.
//  Full register contents are exported flat for debug and testbench observation.
// PARAMETERS
//  DATA_W  8   register / ALU data width
//  REG_N   16  number of registers (power of 2, >=2); ADDR_W = $clog2(REG_N)
//  INSTR_W = 4 + 3*ADDR_W (derived localparam; 16 at defaults)
// PORTS
//  clk          in   1              clock, all logic on rising edge
//  rst          in   1              synchronous, active-high reset
//  instr        in   INSTR_W        {op[3:0], srcA, srcB, dest}; srcA/srcB/dest are ADDR_W bits each, MSB->LSB
//  instr_valid  in   1              instr present
//  instr_ready  out  1              core idle, will accept
//  load_en      in   1              register load strobe
//  load_addr    in   ADDR_W         load target
//  load_data    in   DATA_W         load value
//  done         out  1              one-cycle pulse: instruction retired
//  result       out  DATA_W         last retired result
//  regs_flat    out  REG_N*DATA_W   reg i at [i*DATA_W +: DATA_W]
//  flag_z       out  1              (REGFILE_ALU_FLAGS_EN only) zero
//  flag_c       out  1              (REGFILE_ALU_FLAGS_EN only) carry/borrow/overflow
// BEHAVIOUR
//  - Reset: all regs 0, state IDLE, done 0, result 0, flags 0, mul counter 0. Reset mid-instruction aborts it: no write, no done.
//  - instr_ready = (state==IDLE), combinational from state. Accept = instr_valid & instr_ready at edge E0.
//  - FSM: IDLE -E0-> READ (latch op/dest, read A=reg[srcA], B=reg[srcB]) -E1-> EXEC -> write+done -> IDLE.
//  - Single-cycle ops: at E2 write reg[dest], result<=value, done=1 for the cycle after E2, state IDLE (ready=1 same cycle).
//  - MUL: EXEC lasts DATA_W cycles (counter 0..DATA_W-1, one shift-add step per cycle); write at edge ending last EXEC cycle,
//    i.e. accept-to-write = DATA_W+1 edges (9 at default). Non-MUL accept-to-write = 2 edges.
//  - Opcodes: 1000 AND, 1001 OR, 1010 XOR, 1011 ADD, 1100 SUB (A-B), 1101 MUL, 1110 SHL A<<B, 1111 SHR A>>B (logical).
//    0xxx = NOP: full FSM pass, done pulses, no reg write, result and flags unchanged.
//  - Width: all results truncated to low DATA_W bits, mod 2^DATA_W. Shift with B>=DATA_W gives 0.
//  - dest may equal srcA/srcB: operands latched in READ, so old values are used.
//  - Load port: honoured only when state==IDLE and no accept occurs that cycle; load_en while busy or coinciding with accept
//    is dropped silently. Load does not touch done/result/flags.
//  - instr/instr_valid ignored while instr_ready=0; instr need only be stable in the accept cycle.
// CONFIGURATION
//  REGFILE_ALU_FLAGS_EN defined: flag_z/flag_c ports exist; updated at every non-NOP write:
//    z = (result==0); c = ADD carry-out, SUB borrow (A<B), MUL any nonzero bit above DATA_W, 0 for logic/shift ops.
//  REGFILE_ALU_FLAGS_EN undefined: ports and flag logic absent; all other behaviour identical.
// TESTING
//  1 rst, load r3=5, r7=9; instr 16'b1011_0011_0111_0000 -> r0=14 written 2 edges after accept, done 1 cycle, z=0 c=0.
//  2 load r1=3, r2=5; SUB 1100_0001_0010_0100 -> r4=8'hFE, c=1; then SUB r2-r2 into r5 -> r5=0, z=1, c=0.
//  3 load r6=20, r8=13; MUL 1101_0110_1000_1001 -> r9=8'h04 (260 mod 256) exactly 9 edges after accept, c=1; ready low during.
//  4 during test 3 hold instr_valid=1 with ADD and pulse load_en r10=77 -> both ignored; r10 stays 0; ADD accepted only once ready=1.
//  5 AND r1&r2 into r1 (3&5) -> r1=1 using pre-write operands; SHL r1<<r8 (B=13>=8) -> 0; NOP 0000_* -> done, regs unchanged.
//  6 assert rst during MUL EXEC cycle 4 -> no done, dest reg stays 0, all regs 0, ready=1 the cycle after reset released.

Source files
------------

// File: rtl/regfile_alu_core.sv
// -----------------------------------------------------------------------------
// regfile_alu_core
//   Register file plus ALU execution core. One instruction
//   {op[3:0], src_a, src_b, dest} is accepted per valid/ready handshake. Each
//   instruction passes through READ and EXEC and then writes back. MUL is a
//   DATA_W-cycle shift-add sequence. All other ops take one EXEC cycle. A side
//   load port initialises registers while the core is idle.
//
//   Optional feature macro: REGFILE_ALU_FLAGS_EN adds the zero and carry flag
//   ports (flag_z, flag_c) together with their update logic.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous, active-high reset
//   instr        in   {op, src_a, src_b, dest}
//   instr_valid  in   instr present
//   instr_ready  out  core idle, will accept (combinational from state)
//   load_en      in   register load strobe (IDLE only, dropped on accept)
//   load_addr    in   load target register
//   load_data    in   load value
//   done         out  one-cycle pulse, instruction retired
//   result       out  last retired (non-NOP) result
//   regs_flat    out  register i at [i*DATA_W +: DATA_W]
//   flag_z       out  (REGFILE_ALU_FLAGS_EN) result was zero
//   flag_c       out  (REGFILE_ALU_FLAGS_EN) carry / borrow / MUL overflow
// -----------------------------------------------------------------------------
module regfile_alu_core #(
  parameter  int DATA_W  = 8,
  parameter  int REG_N   = 16,
  localparam int ADDR_W  = $clog2(REG_N),
  localparam int INSTR_W = 4 + 3 * ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [INSTR_W-1:0]      instr,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic                    load_en,
  input  logic [ADDR_W-1:0]       load_addr,
  input  logic [DATA_W-1:0]       load_data,
  output logic                    done,
  output logic [DATA_W-1:0]       result,
  output logic [REG_N*DATA_W-1:0] regs_flat
`ifdef REGFILE_ALU_FLAGS_EN
  ,
  output logic                    flag_z,
  output logic                    flag_c
`endif
);

  localparam logic [3:0] OP_AND = 4'b1000;
  localparam logic [3:0] OP_OR  = 4'b1001;
  localparam logic [3:0] OP_XOR = 4'b1010;
  localparam logic [3:0] OP_ADD = 4'b1011;
  localparam logic [3:0] OP_SUB = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1101;
  localparam logic [3:0] OP_SHL = 4'b1110;
  localparam logic [3:0] OP_SHR = 4'b1111;

  localparam int                CNT_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W:0]   SHIFT_LIM = (DATA_W + 1)'(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC
  } state_t;

  state_t                state;
  logic [3:0]            op_q;
  logic [ADDR_W-1:0]     src_a_q;
  logic [ADDR_W-1:0]     src_b_q;
  logic [ADDR_W-1:0]     dest_q;
  logic [DATA_W-1:0]     a_q;
  logic [DATA_W-1:0]     b_q;
  logic [DATA_W-1:0]     regs [REG_N];

  // Shift-add multiplier: mul_a walks left, mul_b walks right.
  logic [2*DATA_W-1:0]   mul_acc;
  logic [2*DATA_W-1:0]   mul_a;
  logic [DATA_W-1:0]     mul_b;
  logic [CNT_W-1:0]      mul_cnt;
  logic [2*DATA_W-1:0]   mul_acc_next;

  logic [DATA_W-1:0]     alu_val;
  logic                  wb_now;
  logic                  accept;

  assign instr_ready = (state == S_IDLE);
  assign accept      = instr_valid && instr_ready;

  // The final MUL step is folded into the writeback edge, so the product is
  // taken from mul_acc_next, not from mul_acc.
  assign mul_acc_next = mul_acc + (mul_b[0] ? mul_a : '0);

  assign wb_now = (state == S_EXEC) && ((op_q != OP_MUL) || (mul_cnt == CNT_LAST));

  for (genvar gi = 0; gi < REG_N; gi++) begin : g_flat
    assign regs_flat[gi*DATA_W +: DATA_W] = regs[gi];
  end

  // NOTE: every output of a combinational block gets a default before the case;
  // an opcode path that skips the assignment would otherwise infer a latch.
  always_comb begin
    alu_val = '0;
    case (op_q)
      OP_AND: alu_val = a_q & b_q;
      OP_OR:  alu_val = a_q | b_q;
      OP_XOR: alu_val = a_q ^ b_q;
      OP_ADD: alu_val = a_q + b_q;
      OP_SUB: alu_val = a_q - b_q;
      OP_MUL: alu_val = mul_acc_next[DATA_W-1:0];
      OP_SHL: alu_val = ({1'b0, b_q} >= SHIFT_LIM) ? '0 : (a_q << b_q);
      OP_SHR: alu_val = ({1'b0, b_q} >= SHIFT_LIM) ? '0 : (a_q >> b_q);
      default: alu_val = '0;
    endcase
  end

`ifdef REGFILE_ALU_FLAGS_EN
  logic alu_c;

  always_comb begin
    alu_c = 1'b0;
    case (op_q)
      OP_ADD:  alu_c = (alu_val < a_q);    // a truncated sum wraps below a operand only on carry-out
      OP_SUB:  alu_c = (a_q < b_q);
      OP_MUL:  alu_c = |mul_acc_next[2*DATA_W-1:DATA_W];
      default: alu_c = 1'b0;
    endcase
  end
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side sees the values from before this clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      op_q    <= '0;
      src_a_q <= '0;
      src_b_q <= '0;
      dest_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mul_acc <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
      mul_cnt <= '0;
      done    <= 1'b0;
      result  <= '0;
      // NOTE: the register file is flops, not a RAM macro, so it is cleared on
      // reset. An architectural zero state is visible on regs_flat.
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
`ifdef REGFILE_ALU_FLAGS_EN
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q    <= instr[INSTR_W-1 -: 4];
            src_a_q <= instr[3*ADDR_W-1 -: ADDR_W];
            src_b_q <= instr[2*ADDR_W-1 -: ADDR_W];
            dest_q  <= instr[ADDR_W-1:0];
            state   <= S_READ;
          end else if (load_en) begin
            regs[load_addr] <= load_data;
          end
        end

        S_READ: begin
          // Operands are captured here, so dest may safely alias a source.
          a_q     <= regs[src_a_q];
          b_q     <= regs[src_b_q];
          mul_acc <= '0;
          mul_a   <= {{DATA_W{1'b0}}, regs[src_a_q]};
          mul_b   <= regs[src_b_q];
          mul_cnt <= '0;
          state   <= S_EXEC;
        end

        S_EXEC: begin
          if (wb_now) begin
            if (op_q[3]) begin
              regs[dest_q] <= alu_val;
              result       <= alu_val;
`ifdef REGFILE_ALU_FLAGS_EN
              flag_z       <= (alu_val == '0);
              flag_c       <= alu_c;
`endif
            end
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            mul_acc <= mul_acc_next;
            mul_a   <= mul_a << 1;
            mul_b   <= mul_b >> 1;
            mul_cnt <= mul_cnt + 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_alu_core.sv
// -----------------------------------------------------------------------------
// tb_regfile_alu_core
//   Directed bench for regfile_alu_core at its default parameters
//   (DATA_W=8, REG_N=16). The stimulus pushes the hand-computed expected
//   retirements into a scoreboard queue. A monitor pops one entry on every
//   done pulse. For each entry it checks the result, the accept-to-done
//   latency, the destination register and, when REGFILE_ALU_FLAGS_EN is
//   defined, the flags.
// -----------------------------------------------------------------------------
module tb_regfile_alu_core;

  localparam int DATA_W  = 8;
  localparam int REG_N   = 16;
  localparam int ADDR_W  = 4;
  localparam int INSTR_W = 16;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [INSTR_W-1:0]      instr;
  logic                    instr_valid;
  logic                    instr_ready;
  logic                    load_en;
  logic [ADDR_W-1:0]       load_addr;
  logic [DATA_W-1:0]       load_data;
  logic                    done;
  logic [DATA_W-1:0]       result;
  logic [REG_N*DATA_W-1:0] regs_flat;
`ifdef REGFILE_ALU_FLAGS_EN
  logic                    flag_z;
  logic                    flag_c;
`endif

  regfile_alu_core #(.DATA_W(DATA_W), .REG_N(REG_N)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .done        (done),
    .result      (result),
    .regs_flat   (regs_flat)
`ifdef REGFILE_ALU_FLAGS_EN
    ,
    .flag_z      (flag_z),
    .flag_c      (flag_c)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      name;
    logic [7:0] res;
    int         dest;
    bit         wr;
    logic       z;
    logic       c;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Offers one instruction and waits, with a bound, for it to be accepted.
  // Accept-to-done latency is counted in bench cycles: 3 for single-cycle ops
  // (accept edge, READ edge, write edge) and DATA_W+2 for MUL.
  task automatic issue(input string name, input logic [15:0] ins, input logic [7:0] res,
                       input bit wr, input logic z, input logic c, input bit expect_done);
    exp_t e;
    int   budget = 0;
    instr       = ins;
    instr_valid = 1'b1;
    while (!instr_ready && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    check({name, "_accept_timeout"}, {127'd0, instr_ready}, 128'd1);
    if (instr_ready && expect_done) begin
      e.name = name;
      e.res  = res;
      e.dest = int'(ins[3:0]);
      e.wr   = wr;
      e.z    = z;
      e.c    = c;
      e.lat  = (ins[15:12] == 4'b1101) ? DATA_W + 2 : 3;
      e.acc  = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    instr_valid = 1'b0;
    instr       = '0;
  endtask

  task automatic load(input int addr, input logic [7:0] data);
    load_en   = 1'b1;
    load_addr = ADDR_W'(addr);
    load_data = data;
    @(negedge clk);
    load_en   = 1'b0;
  endtask

  task automatic drain(input string name);
    int budget = 0;
    while (sb.size() != 0 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check({name, "_drain"}, 128'(sb.size()), 128'd0);
    @(negedge clk);
  endtask

  function automatic logic [7:0] rg(input int i);
    return regs_flat[i*DATA_W +: DATA_W];
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 128'd1, 128'd0);
      end else begin
        e = sb.pop_front();
        check({e.name, "_result"}, 128'(result), 128'(e.res));
        check({e.name, "_latency"}, 128'(cyc - e.acc), 128'(e.lat));
        if (e.wr) check({e.name, "_dest_reg"}, 128'(rg(e.dest)), 128'(e.res));
`ifdef REGFILE_ALU_FLAGS_EN
        check({e.name, "_flag_z"}, 128'(flag_z), 128'(e.z));
        check({e.name, "_flag_c"}, 128'(flag_c), 128'(e.c));
`endif
      end
    end
  end

  // Hand-computed register file contents after tests 1-5.
  logic [7:0] final_regs [REG_N] = '{8'd14, 8'd1, 8'd5, 8'd5, 8'hFE, 8'd0, 8'd20, 8'd9,
                                     8'd13, 8'd4, 8'd0, 8'd14, 8'd0, 8'd13, 8'd25, 8'd10};

  initial begin
    logic [REG_N*DATA_W-1:0] exp_flat;

    rst = 1'b1; instr = '0; instr_valid = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready",  128'(instr_ready), 128'd1);
    check("reset_done",   128'(done),        128'd0);
    check("reset_result", 128'(result),      128'd0);
    check("reset_regs",   128'(regs_flat),   128'd0);

    // Test 1: ADD r3+r7 -> r0.
    load(3, 8'd5);
    load(7, 8'd9);
    issue("add_r0", 16'b1011_0011_0111_0000, 8'd14, 1'b1, 1'b0, 1'b0, 1'b1);
    drain("t1");

    // Test 2: SUB with borrow, then SUB of a register with itself.
    load(1, 8'd3);
    load(2, 8'd5);
    issue("sub_r4", 16'b1100_0001_0010_0100, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b1);
    drain("t2a");
    issue("sub_r5", 16'b1100_0010_0010_0101, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
    drain("t2b");

    // Tests 3 and 4: MUL 20*13 = 260 -> 0x04. The next ADD is held valid and a
    // load is pulsed while the core is busy.
    load(6, 8'd20);
    load(8, 8'd13);
    issue("mul_r9", 16'b1101_0110_1000_1001, 8'h04, 1'b1, 1'b0, 1'b1, 1'b1);
    instr       = 16'b1011_0011_0111_1011;
    instr_valid = 1'b1;
    load_en     = 1'b1;
    load_addr   = 4'd10;
    load_data   = 8'd77;
    check("busy_ready_0", 128'(instr_ready), 128'd0);
    @(negedge clk);
    load_en = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("busy_ready_%0d", i), 128'(instr_ready), 128'd0);
      @(negedge clk);
    end
    issue("add_held_r11", 16'b1011_0011_0111_1011, 8'd14, 1'b1, 1'b0, 1'b0, 1'b1);
    drain("t4");
    check("busy_load_r10", 128'(rg(10)), 128'd0);

    // Test 5: aliasing dest with a source, oversized shift, logic ops, NOP.
    issue("and_r1",  16'b1000_0001_0010_0001, 8'd1,  1'b1, 1'b0, 1'b0, 1'b1);
    drain("t5a");
    check("and_src_b_kept", 128'(rg(2)), 128'd5);
    issue("shl_r12", 16'b1110_0001_1000_1100, 8'd0,  1'b1, 1'b1, 1'b0, 1'b1);
    issue("xor_r14", 16'b1010_0110_1000_1110, 8'd25, 1'b1, 1'b0, 1'b0, 1'b1);
    issue("shr_r15", 16'b1111_0110_0001_1111, 8'd10, 1'b1, 1'b0, 1'b0, 1'b1);
    issue("or_r13",  16'b1001_0011_0111_1101, 8'd13, 1'b1, 1'b0, 1'b0, 1'b1);
    issue("nop",     16'b0000_0001_0010_0011, 8'd13, 1'b0, 1'b0, 1'b0, 1'b1);
    drain("t5b");
    for (int i = 0; i < REG_N; i++) exp_flat[i*DATA_W +: DATA_W] = final_regs[i];
    check("final_regs", 128'(regs_flat), 128'(exp_flat));

    // Test 6: reset during EXEC cycle 4 of a MUL aborts it.
    issue("mul_abort", 16'b1101_0110_1000_1001, 8'h04, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready",  128'(instr_ready), 128'd1);
    check("abort_done",   128'(done),        128'd0);
    check("abort_result", 128'(result),      128'd0);
    check("abort_regs",   128'(regs_flat),   128'd0);
`ifdef REGFILE_ALU_FLAGS_EN
    check("abort_flags",  128'({flag_z, flag_c}), 128'd0);
`endif
    repeat (15) @(negedge clk);
    check("abort_r9_after", 128'(rg(9)),     128'd0);
    check("abort_regs_after", 128'(regs_flat), 128'd0);
    drain("end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
